vga_pixel_source: RTL and testbench
===================================

Name: vga_pixel_source

Overview:
- Produces the `colour` / `colour_enable` stream that feeds the VGA colour output register stage. It is the source end of that interface.
- Generates 640x480@60 timing counters and hsync/vsync.
- Fetches tank sprite pixels from a synchronous ROM and composites them over a background colour.
- Sits between the game logic (sprite position) and the VGA output register.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in lines
- ADDR_W, 10, ROM address width (log2(SPRITE_W*SPRITE_H))
- ROM_LATENCY, 1, cycles from rom_addr to valid rom_data (1..3)
- SYNC_ALIGN, 1, extra sync delay matching the downstream colour register
- TRANSPARENT, 12'hF0F, ROM value treated as transparent
- BG_COLOUR, 12'h000, background colour

Ports:
- clk  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- sprite_x  in  10  sprite left column, screen coordinates
- sprite_y  in  10  sprite top line, screen coordinates
- rom_data  in  12  ROM pixel, {R[11:8],G[7:4],B[3:0]}
- rom_addr  out  ADDR_W  ROM pixel address
- colour  out  12  pixel colour to the output stage
- colour_enable  out  1  high while the pixel is in the visible area
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- frame_start  out  1  one-cycle pulse at counter position (0,0)

Behaviour:
- Reset (async assert, deasserted synchronously by the clock domain):
  - h_cnt=0, v_cnt=0, rom_addr=0, colour=0, colour_enable=0, hsync=1, vsync=1, frame_start=0.
  - Latched sprite position = (0,0); all delay-line stages cleared to inactive.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL=800), then wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1 (V_TOTAL=525), then wraps to 0.
- Sprite position:
  - sx/sy are sampled from sprite_x/sprite_y only in the cycle where h_cnt=0 and v_cnt=0.
  - Mid-frame changes therefore never tear the image.
  - frame_start=1 in that same cycle (counter stage, not delayed).
- Stage 0, counter stage (cycle t):
  - vis = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - in_spr = h_cnt >= sx && h_cnt < sx+SPRITE_W && v_cnt >= sy && v_cnt < sy+SPRITE_H.
  - in_spr comparisons use 11-bit sums, so a sprite partly off the right or bottom edge is clipped with no wrap.
- Stage 1 (t+1):
  - rom_addr registered = (v_cnt-sy)*SPRITE_W + (h_cnt-sx) when in_spr, else 0.
  - Multiply is a shift.
- Stage 2 (t+1+ROM_LATENCY): rom_data is valid.
- Output stage (t+2+ROM_LATENCY): colour and colour_enable are registered together.
  - colour_enable = vis delayed.
  - colour = 0 when !vis.
  - colour = BG_COLOUR when vis && (!in_spr || rom_data==TRANSPARENT).
  - colour = rom_data otherwise.
- Sync outputs:
  - hsync raw = !(h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. 656..751.
  - vsync raw = !(v_cnt in [490,491]).
  - Both are delayed by D_SYNC = 2+ROM_LATENCY+SYNC_ALIGN registers, so they align with RGB after the downstream register.
- Pipeline properties:
  - Latency from counter stage: D_PIX = 2+ROM_LATENCY for colour/colour_enable; D_SYNC for sync.
  - in_spr and vis travel in a shift register alongside the ROM access.
  - No stalls; the pipeline accepts one pixel per clock.
- Reset mid-frame: everything returns to reset values immediately, and counting restarts at (0,0) on the first clock after release.

Test Plan:
- Release reset, run 2 frames -> frame_start pulses exactly every 420000 cycles.
  - Each hsync low window lasts exactly 96 cycles; each vsync low window lasts exactly 1600 cycles (2 lines).
  - colour_enable is high for 640 consecutive cycles on each of lines 0..479, 307200 cycles per frame.
- sprite_x=100, sprite_y=50, ROM model returns data=addr[11:0] with ROM_LATENCY=1:
  - Pixel (100,50) gives colour=12'h000 aligned 3 cycles after its counter cycle.
  - Pixel (131,81) gives rom_addr=1023 and colour=12'h3FF.
  - Pixel (132,50) gives colour=BG_COLOUR.
- ROM returns 12'hF0F at address 5 -> pixel (105,50) outputs BG_COLOUR, not 12'hF0F.
- sprite_x=620, sprite_y=470 -> sprite pixels appear only for h 620..639 and v 470..479.
  - No sprite pixel appears at h 0..11 or v 0..21 (no wrap).
- Change sprite_x from 100 to 200 at line 10 -> current frame still draws at x=100; next frame draws at x=200.
- Assert resetn low at h_cnt=300, v_cnt=200 for 3 cycles -> outputs immediately reset (hsync=1, vsync=1, colour_enable=0, colour=0).
  - frame_start pulses on the first clock after release.

Source files
------------

// File: rtl/vga_pixel_source.sv
// vga_pixel_source
// Source end of the VGA colour stream: free-running 640x480@60 timing
// counters, a sprite window over a synchronous tank ROM, and a compositor
// that lays the sprite over a flat background. Sync outputs are delayed
// further than the colour so they line up after the downstream register.
module vga_pixel_source #(
    parameter int          H_VISIBLE   = 640,
    parameter int          H_FRONT     = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BACK      = 48,
    parameter int          V_VISIBLE   = 480,
    parameter int          V_FRONT     = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BACK      = 33,
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          ADDR_W      = 10,
    parameter int          ROM_LATENCY = 1,
    parameter int          SYNC_ALIGN  = 1,
    parameter logic [11:0] TRANSPARENT = 12'hF0F,
    parameter logic [11:0] BG_COLOUR   = 12'h000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [11:0]       rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [11:0]       colour,
    output logic              colour_enable,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    // Frame geometry
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Sprite window extents, held at 11 bits so edge sprites clip instead of wrapping
    localparam logic [10:0] SPR_W11 = 11'(SPRITE_W);
    localparam logic [10:0] SPR_H11 = 11'(SPRITE_H);
    localparam int          SW_LOG2 = $clog2(SPRITE_W);

    // Pipeline depths measured from the counter stage
    localparam int PIPE_LEN = ROM_LATENCY + 1;
    localparam int D_SYNC   = 2 + ROM_LATENCY + SYNC_ALIGN;

    // Counter stage state
    logic        running;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [9:0]  sx;
    logic [9:0]  sy;

    // Counter stage decode
    logic        at_origin;
    logic [9:0]  cur_sx;
    logic [9:0]  cur_sy;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic [10:0] sx_ext;
    logic [10:0] sy_ext;
    logic        vis_s0;
    logic        in_spr_s0;
    logic        hs_raw;
    logic        vs_raw;
    logic [ADDR_W-1:0] dx_a;
    logic [ADDR_W-1:0] dy_a;
    logic [ADDR_W-1:0] addr_next;

    // Delay lines travelling alongside the ROM access and towards the sync pins
    logic [PIPE_LEN-1:0] vis_pipe;
    logic [PIPE_LEN-1:0] spr_pipe;
    logic [D_SYNC-1:0]   hs_pipe;
    logic [D_SYNC-1:0]   vs_pipe;

    logic [11:0] colour_next;

    // Holds the counters at (0,0) for the first clock after reset so that
    // the origin cycle (and its frame_start pulse) starts on that clock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    // Horizontal and vertical raster counters, vertical steps on the horizontal wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (running) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 10'd0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= 10'd0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign at_origin   = running && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign frame_start = at_origin;

    // Sprite position is captured once per frame at the origin so a move never tears
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sx <= 10'd0;
            sy <= 10'd0;
        end else if (at_origin) begin
            sx <= sprite_x;
            sy <= sprite_y;
        end
    end

    // The origin pixel already belongs to the new frame, so it sees the live inputs
    assign cur_sx = at_origin ? sprite_x : sx;
    assign cur_sy = at_origin ? sprite_y : sy;

    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign sx_ext = {1'b0, cur_sx};
    assign sy_ext = {1'b0, cur_sy};

    assign vis_s0    = running && (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    assign in_spr_s0 = running
                    && (h_ext >= sx_ext) && (h_ext < sx_ext + SPR_W11)
                    && (v_ext >= sy_ext) && (v_ext < sy_ext + SPR_H11);

    assign hs_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

    // Offsets inside the sprite; the row stride is a shift since SPRITE_W is a power of two
    assign dx_a      = ADDR_W'(h_cnt - cur_sx);
    assign dy_a      = ADDR_W'(v_cnt - cur_sy);
    assign addr_next = in_spr_s0 ? ((dy_a << SW_LOG2) + dx_a) : '0;

    // Stage 1: registered ROM address
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rom_addr <= '0;
        end else begin
            rom_addr <= addr_next;
        end
    end

    // Visibility and sprite hit ride along until the ROM word arrives
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vis_pipe <= '0;
            spr_pipe <= '0;
        end else begin
            vis_pipe <= {vis_pipe[PIPE_LEN-2:0], vis_s0};
            spr_pipe <= {spr_pipe[PIPE_LEN-2:0], in_spr_s0};
        end
    end

    // Compositor: black outside the visible area, background where no opaque sprite pixel
    always_comb begin
        colour_next = 12'h000;
        if (vis_pipe[PIPE_LEN-1]) begin
            if (!spr_pipe[PIPE_LEN-1] || (rom_data == TRANSPARENT)) begin
                colour_next = BG_COLOUR;
            end else begin
                colour_next = rom_data;
            end
        end
    end

    // Output stage: colour and its enable leave together
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            colour        <= 12'h000;
            colour_enable <= 1'b0;
        end else begin
            colour        <= colour_next;
            colour_enable <= vis_pipe[PIPE_LEN-1];
        end
    end

    // Sync delay lines, idle high, one stage longer than colour to cover the downstream register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            hs_pipe <= {hs_pipe[D_SYNC-2:0], hs_raw};
            vs_pipe <= {vs_pipe[D_SYNC-2:0], vs_raw};
        end
    end

    assign hsync = hs_pipe[D_SYNC-1];
    assign vsync = vs_pipe[D_SYNC-1];

endmodule

// File: tb/tb_vga_pixel_source.sv
// tb_vga_pixel_source
// Drives vga_pixel_source on a reduced raster so several frames fit in a
// short run, with a synchronous ROM model and a cycle-level reference that
// derives every output from the raster position and the frame's sprite.
module tb_vga_pixel_source;

    // Reduced geometry for the instance under test
    localparam int HV = 64, HF = 6, HS = 10, HB = 8;
    localparam int VV = 40, VF = 3, VS = 2, VB = 5;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int SW = 16, SH = 16, AW = 8;
    localparam int LAT = 1, ALIGN = 1;
    localparam int D_PIX = 2 + LAT;
    localparam int D_SYN = 2 + LAT + ALIGN;
    localparam logic [11:0] TR = 12'hF0F;
    localparam logic [11:0] BG = 12'h123;

    logic          clk;
    logic          resetn;
    logic [9:0]    sprite_x;
    logic [9:0]    sprite_y;
    logic [11:0]   rom_data;
    logic [AW-1:0] rom_addr;
    logic [11:0]   colour;
    logic          colour_enable;
    logic          hsync;
    logic          vsync;
    logic          frame_start;

    vga_pixel_source #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SPRITE_W(SW), .SPRITE_H(SH), .ADDR_W(AW),
        .ROM_LATENCY(LAT), .SYNC_ALIGN(ALIGN),
        .TRANSPARENT(TR), .BG_COLOUR(BG)
    ) dut (
        .clk(clk), .resetn(resetn),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .rom_data(rom_data), .rom_addr(rom_addr),
        .colour(colour), .colour_enable(colour_enable),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    logic [11:0] mem [0:255];
    int fsx [0:63];
    int fsy [0:63];
    int edges = 0;
    int checks = 0;
    int passes = 0;
    int fails = 0;

    // Measurement trackers for window lengths and periods
    int tnow = 0;
    int fs_last = 0;
    bit fs_seen = 0;
    int hs_len = 0, vs_len = 0, en_len = 0, en_frame = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1, en_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
            if (fails >= 200) begin
                $display("%0d/%0d checks passed", passes, checks);
                $finish;
            end
        end else begin
            passes++;
        end
    endtask

    // Raster position and frame number of counter cycle j since reset release
    function automatic void coordOf(input int j, output int h, output int v, output int f);
        int pos;
        pos = j % FRAME;
        f = j / FRAME;
        h = pos % HT;
        v = pos / HT;
    endfunction

    function automatic bit refInSprite(input int j, output int a);
        int h, v, f, sx, sy;
        coordOf(j, h, v, f);
        sx = fsx[f];
        sy = fsy[f];
        a = 0;
        if (h >= sx && h < sx + SW && v >= sy && v < sy + SH) begin
            a = (v - sy) * SW + (h - sx);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [12:0] refPixel(input int j);
        int h, v, f, a;
        coordOf(j, h, v, f);
        if (!(h < HV && v < VV)) return 13'h0;
        if (refInSprite(j, a) && mem[a] != TR) return {1'b1, mem[a]};
        return {1'b1, BG};
    endfunction

    function automatic logic [1:0] refSync(input int j);
        int h, v, f;
        logic hs, vs;
        coordOf(j, h, v, f);
        hs = !(h >= HV + HF && h < HV + HF + HS);
        vs = !(v >= VV + VF && v < VV + VF + VS);
        return {hs, vs};
    endfunction

    // Synchronous ROM, edge counting and per-frame sprite capture
    always @(posedge clk) begin
        rom_data <= mem[rom_addr];
        if (!resetn) begin
            edges = 0;
        end else begin
            if (edges >= 1 && ((edges - 1) % FRAME) == 0) begin
                fsx[(edges - 1) / FRAME] = int'(sprite_x);
                fsy[(edges - 1) / FRAME] = int'(sprite_y);
            end
            edges++;
        end
    end

    // Every cycle: compare against the reference and measure sync/enable windows
    always @(negedge clk) begin
        int j, a;
        logic [12:0] px;
        logic [1:0] sy;
        tnow++;
        if (!resetn || edges == 0) begin
            checkOutput("rst_fs", 32'(frame_start), 32'd0);
            checkOutput("rst_addr", 32'(rom_addr), 32'd0);
            checkOutput("rst_pix", 32'({colour_enable, colour}), 32'd0);
            checkOutput("rst_sync", 32'({hsync, vsync}), 32'd3);
            fs_seen = 0;
            hs_len = 0; vs_len = 0; en_len = 0; en_frame = 0;
            hs_prev = 1'b1; vs_prev = 1'b1; en_prev = 1'b0;
        end else begin
            j = edges - 1;
            checkOutput("fs", 32'(frame_start), 32'((j % FRAME) == 0));
            if (j >= 1 && refInSprite(j - 1, a)) checkOutput("addr", 32'(rom_addr), 32'(a));
            else checkOutput("addr", 32'(rom_addr), 32'd0);
            px = (j >= D_PIX) ? refPixel(j - D_PIX) : 13'h0;
            checkOutput("pix", 32'({colour_enable, colour}), 32'(px));
            sy = (j >= D_SYN) ? refSync(j - D_SYN) : 2'b11;
            checkOutput("sync", 32'({hsync, vsync}), 32'(sy));

            if (frame_start) begin
                if (fs_seen) begin
                    checkOutput("fs_period", 32'(tnow - fs_last), 32'(FRAME));
                    checkOutput("en_per_frame", 32'(en_frame), 32'(HV * VV));
                end
                fs_seen = 1;
                fs_last = tnow;
                en_frame = 0;
            end
            if (colour_enable) begin en_len++; en_frame++; end
            else if (en_prev) begin checkOutput("en_run", 32'(en_len), 32'(HV)); en_len = 0; end
            if (!hsync) hs_len++;
            else if (!hs_prev) begin checkOutput("hs_width", 32'(hs_len), 32'(HS)); hs_len = 0; end
            if (!vsync) vs_len++;
            else if (!vs_prev) begin checkOutput("vs_width", 32'(vs_len), 32'(VS * HT)); vs_len = 0; end
            hs_prev = hsync; vs_prev = vsync; en_prev = colour_enable;
        end
    end

    // Wait (bounded) for the negedge of the counter cycle at raster (h,v)
    task automatic waitCounter(input int h, input int v);
        bit found = 0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            @(negedge clk);
            if (resetn && edges >= 1 && ((edges - 1) % FRAME) == v * HT + h) found = 1;
        end
        checkOutput("wait_hv", 32'(found), 32'd1);
    endtask

    // Directed pixel: ROM address one cycle later, composited colour D_PIX cycles later
    task automatic checkPixel(input string tag, input int h, input int v,
                              input logic [AW-1:0] exp_addr, input logic [11:0] exp_col);
        waitCounter(h, v);
        @(negedge clk);
        checkOutput({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        repeat (D_PIX - 1) @(negedge clk);
        checkOutput({tag, "_col"}, 32'({colour_enable, colour}), 32'({1'b1, exp_col}));
    endtask

    task automatic randomSprite();
        if ($urandom_range(0, 3) == 0) begin
            sprite_x = 10'($urandom_range(1000, 1023));
            sprite_y = 10'($urandom_range(1000, 1023));
        end else begin
            sprite_x = 10'($urandom_range(0, HV + 4));
            sprite_y = 10'($urandom_range(0, VV + 4));
        end
    endtask

    // Random ROM contents and sprite moves at arbitrary cycles over several frames
    task automatic applyStimulus(input int frames);
        sprite_x = 10'd30;
        sprite_y = 10'd12;
        for (int n = 0; n < frames * FRAME; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 1499) == 0) randomSprite();
        end
    endtask

    initial begin
        resetn = 1'b0;
        sprite_x = 10'd20;
        sprite_y = 10'd10;
        for (int a = 0; a < 256; a++) mem[a] = 12'(a);
        mem[5] = TR;
        repeat (4) @(negedge clk);
        checkOutput("init_hsync", 32'(hsync), 32'd1);
        checkOutput("init_vsync", 32'(vsync), 32'd1);
        checkOutput("init_fs", 32'(frame_start), 32'd0);
        #1 resetn = 1'b1;

        // Frame 0: corners of the sprite, transparency, right of the sprite
        checkPixel("p20_10", 20, 10, 8'd0, 12'h000);
        checkPixel("p25_10_transp", 25, 10, 8'd5, BG);
        checkPixel("p36_10_bg", 36, 10, 8'd0, BG);
        checkPixel("p35_25_last", 35, 25, 8'd255, 12'h0FF);

        // Frame 1: move mid-frame, image must not follow until next frame
        waitCounter(0, 12);
        sprite_x = 10'd40;
        checkPixel("f1_p20_20", 20, 20, 8'd160, 12'h0A0);
        checkPixel("f1_p40_20", 40, 20, 8'd0, BG);
        checkPixel("f2_p20_20", 20, 20, 8'd0, BG);
        checkPixel("f2_p40_20", 40, 20, 8'd160, 12'h0A0);

        // Frame 3: sprite clipped by the right and bottom edges
        waitCounter(0, 45);
        sprite_x = 10'd56;
        sprite_y = 10'd34;
        checkPixel("f3_p55_34", 55, 34, 8'd0, BG);
        checkPixel("f3_p63_39", 63, 39, 8'd87, 12'h057);

        // Frame 4: sprite near the top of the coordinate range must not wrap
        waitCounter(0, 45);
        sprite_x = 10'd1020;
        sprite_y = 10'd1020;
        checkPixel("f4_p2_2_nowrap", 2, 2, 8'd0, BG);

        // Mid-frame reset for three cycles
        waitCounter(30, 20);
        #1 resetn = 1'b0;
        #1;
        checkOutput("mid_rst_hsync", 32'(hsync), 32'd1);
        checkOutput("mid_rst_vsync", 32'(vsync), 32'd1);
        checkOutput("mid_rst_pix", 32'({colour_enable, colour}), 32'd0);
        checkOutput("mid_rst_fs", 32'(frame_start), 32'd0);
        for (int a = 0; a < 256; a++)
            mem[a] = ($urandom_range(0, 7) == 0) ? TR : 12'($urandom());
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        checkOutput("fs_after_rst", 32'(frame_start), 32'd1);

        applyStimulus(5);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
